mem_arbiter_n: RTL and testbench

//  Parametrised byte-serial memory arbiter/controller. It sits between NUM_CH requesters
//  (channel 0 = instruction cache, channel 1 = load/store buffer, further channels for
//  new clients) and the single 8-bit RAM/IO bus.

---
 rtl/mem_arbiter_n.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter_n.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: round-robin arbiter / byte-serial controller between NUM_CH
// requesters and a single 8-bit RAM/IO bus. One transaction at a time; multi-byte
// reads and writes are serialised one byte per cycle.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   rdy             0 = freeze all state (mem_wr forced low)
//   clear           pipeline flush; aborts masked-channel reads, masks their reqs
//   io_buffer_full  UART tx full; stalls writes to the IO window (addr[17:16]==3)
//   mem_din         read byte, valid the cycle after its address
//   mem_dout/mem_a/mem_wr  bus write byte / byte address / write strobe
//   req/wr/len/addr/wdata  per-channel request, packed channel c at slice c
//   done            one-cycle completion pulse for the granted channel
//   rdata           last completed read result (bytes >= len are zero)
module mem_arbiter_n #(
  parameter int                NUM_CH     = 2,
  parameter int                DATA_W     = 64,
  parameter int                LEN_W      = 4,
  parameter logic [NUM_CH-1:0] CLEAR_MASK = {NUM_CH{1'b1}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     clear,
  input  logic                     io_buffer_full,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [31:0]              mem_a,
  output logic                     mem_wr,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        wr,
  input  logic [NUM_CH*LEN_W-1:0]  len,
  input  logic [NUM_CH*32-1:0]     addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        done,
  output logic [DATA_W-1:0]        rdata
);
  localparam int MAX_B = DATA_W / 8;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(MAX_B + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, nxt;
  logic [CH_W-1:0]    rr, gnt, win;
  logic               found;
  logic [NUM_CH-1:0]  elig;
  logic [LEN_W-1:0]   len_sel;
  logic [CNT_W-1:0]   n_sel, op_n, icnt;
  logic               op_wr;
  logic [31:0]        op_addr, cur_a;
  logic [DATA_W-1:0]  op_wdata, rbuf, rbuf_nxt;
  logic               stall, abort, last;

  assign elig  = req & ~(CLEAR_MASK & {NUM_CH{clear}});
  assign cur_a = op_addr + 32'(icnt);
  assign stall = op_wr && (cur_a[17:16] == 2'b11) && io_buffer_full;
  assign abort = !op_wr && clear && CLEAR_MASK[gnt];
  // Reads run one extra cycle (icnt == op_n) to capture the last delayed byte.
  assign last  = op_wr ? ((icnt == op_n - CNT_W'(1)) && !stall) : (icnt == op_n);

  // Round-robin pick: first eligible channel at or above rr+1, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      int idx;
      idx = (int'(rr) + k) % NUM_CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = CH_W'(idx);
      end
    end
  end

  // Winner's byte count: 0 means one byte, oversize clamps to MAX_B.
  always_comb begin
    len_sel = len[int'(win)*LEN_W +: LEN_W];
    if (len_sel == '0)              n_sel = CNT_W'(1);
    else if (int'(len_sel) > MAX_B) n_sel = CNT_W'(MAX_B);
    else                            n_sel = CNT_W'(len_sel);
  end

  always_comb begin
    rbuf_nxt = rbuf;
    if (icnt != '0) rbuf_nxt[(int'(icnt) - 1)*8 +: 8] = mem_din;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= nxt;
  end

  // FSM: next state
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (found) nxt = RUN;
      RUN:     if (abort) nxt = IDLE;
               else if (last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    done     = '0;
    case (state)
      RUN: begin
        if (op_wr) begin
          mem_a    = cur_a;
          mem_dout = op_wdata[int'(icnt)*8 +: 8];
          mem_wr   = rdy && !stall;
        end else if (!rdy && icnt != '0) begin
          // While frozen, keep re-presenting the address whose byte is still
          // owed, so mem_din carries the right byte on the first live cycle.
          mem_a = cur_a - 32'd1;
        end else if (icnt < op_n) begin
          mem_a = cur_a;
        end
      end
      DONE:    done[gnt] = rdy;
      default: ;
    endcase
  end

  // Datapath: grant latch, byte counter, read assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr       <= CH_W'(NUM_CH - 1);
      gnt      <= '0;
      op_wr    <= 1'b0;
      op_n     <= '0;
      op_addr  <= '0;
      op_wdata <= '0;
      icnt     <= '0;
      rbuf     <= '0;
      rdata    <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: if (found) begin
          gnt      <= win;
          rr       <= win;
          op_wr    <= wr[win];
          op_n     <= n_sel;
          op_addr  <= addr[int'(win)*32 +: 32];
          op_wdata <= wdata[int'(win)*DATA_W +: DATA_W];
          icnt     <= '0;
          rbuf     <= '0;
        end
        RUN: begin
          if (op_wr) begin
            if (!stall) icnt <= icnt + CNT_W'(1);
          end else if (!abort) begin
            rbuf <= rbuf_nxt;
            if (icnt < op_n) icnt <= icnt + CNT_W'(1);
            if (last) rdata <= rbuf_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter_n.sv
// Scoreboard bench for mem_arbiter_n: stimulus pushes expected done pulses and bus
// writes into queues; a negedge monitor pops and compares them as they appear.
module tb_mem_arbiter_n;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rdy = 1'b1;
  logic         clear = 1'b0;
  logic         io_buffer_full = 1'b0;
  logic [7:0]   mem_din = '0;
  logic [7:0]   mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;
  logic [1:0]   req = '0;
  logic [1:0]   wr = '0;
  logic [7:0]   len = '0;
  logic [63:0]  addr = '0;
  logic [127:0] wdata = '0;
  logic [1:0]   done;
  logic [63:0]  rdata;

  mem_arbiter_n dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .req(req), .wr(wr), .len(len), .addr(addr), .wdata(wdata),
    .done(done), .rdata(rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: synchronous read, indexed by the low address byte.
  logic [7:0] ram [0:255];
  always @(posedge clk) mem_din <= ram[mem_a[7:0]];

  typedef struct { int ch; bit rd; logic [63:0] data; int cy; } done_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  done_t dq[$];
  wr_t   wq[$];

  function automatic logic [63:0] exp_read(input logic [31:0] a, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*8 +: 8] = ram[8'(a + 32'(i))];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input bit w, input int l, input logic [31:0] a,
                        input logic [63:0] d);
    wr[ch]            = w;
    len[ch*4 +: 4]    = 4'(l);
    addr[ch*32 +: 32] = a;
    wdata[ch*64 +: 64] = d;
  endtask

  task automatic exp_done(input int ch, input bit rd, input logic [63:0] d, input int cy);
    done_t e;
    e.ch = ch; e.rd = rd; e.data = d; e.cy = cy;
    dq.push_back(e);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a; e.d = d;
    wq.push_back(e);
  endtask

  // Hold req until done[ch] shows, then drop it in that same cycle.
  task automatic run_until_done(input int ch);
    for (int k = 0; k < 60 && !done[ch]; k++) step();
    if (!done[ch]) begin
      checks++;
      failures++;
      $display("FAIL timeout_done ch=%0d actual=no done required=done (cyc %0d)", ch, cyc);
    end
    req[ch] = 1'b0;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (done != '0) begin
        checks++;
        if (dq.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected actual=%b required=none (cyc %0d)", done, cyc);
        end else begin
          done_t e;
          e = dq.pop_front();
          if (done != (2'b01 << e.ch) || cyc != e.cy || (e.rd && rdata != e.data)) begin
            failures++;
            $display("FAIL done actual=%b cyc=%0d rdata=%h required ch=%0d cyc=%0d rdata=%h",
                     done, cyc, rdata, e.ch, e.cy, e.rd ? e.data : rdata);
          end
        end
      end
      if (mem_wr) begin
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL write_unexpected actual=%h:%h required=none (cyc %0d)", mem_a, mem_dout, cyc);
        end else begin
          wr_t w;
          w = wq.pop_front();
          if (mem_a != w.a || mem_dout != w.d) begin
            failures++;
            $display("FAIL write actual=%h:%h required=%h:%h (cyc %0d)", mem_a, mem_dout, w.a, w.d, cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, seen;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i*13 + 7);
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_mem_a", 64'(mem_a), 64'h0);
    chk("reset_mem_wr", 64'(mem_wr), 64'h0);
    chk("reset_done", 64'(done), 64'h0);
    chk("reset_rdata", rdata, 64'h0);

    // Two continuous 8-byte readers from reset: grants 0,1,0,1, 11-cycle period.
    set_ch(0, 0, 8, 32'h210, '0);
    set_ch(1, 0, 8, 32'h320, '0);
    c0 = cyc;
    exp_done(0, 1, exp_read(32'h210, 8), c0 + 10);
    exp_done(1, 1, exp_read(32'h320, 8), c0 + 21);
    exp_done(0, 1, exp_read(32'h210, 8), c0 + 32);
    exp_done(1, 1, exp_read(32'h320, 8), c0 + 43);
    req = 2'b11;
    seen = 0;
    for (int k = 0; k < 80 && seen < 4; k++) begin
      step();
      if (done != '0) seen++;
    end
    chk("rr_done_count", 64'(seen), 64'd4);
    req = '0;

    // Read ch1, 4 bytes at 0x100.
    step();
    set_ch(1, 0, 4, 32'h100, '0);
    c0 = cyc;
    exp_done(1, 1, 64'h44332211, c0 + 6);
    req[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rd_addr", 64'(mem_a), 64'(32'h100 + 32'(i)));
    end
    run_until_done(1);

    // IO write stalled 3 cycles by a full UART buffer.
    step();
    set_ch(1, 1, 1, 32'h30000, 64'h41);
    c0 = cyc;
    exp_wr(32'h30000, 8'h41);
    exp_done(1, 0, '0, c0 + 5);
    req[1] = 1'b1;
    step(); io_buffer_full = 1'b1;
    step(); step();
    step(); io_buffer_full = 1'b0;
    run_until_done(1);

    // Masked read aborted by clear in cycle 3.
    step();
    set_ch(0, 0, 8, 32'h240, '0);
    req[0] = 1'b1;
    step(); step();
    step(); clear = 1'b1;
    step(); clear = 1'b0; req[0] = 1'b0;
    chk("abort_idle_bus", 64'(mem_a), 64'h0);
    chk("abort_rdata_kept", rdata, 64'h44332211);
    repeat (12) step();
    // clear masks a fresh request; it is accepted once clear drops.
    set_ch(1, 0, 2, 32'h105, '0);
    req[1] = 1'b1; clear = 1'b1;
    c0 = cyc;
    exp_done(1, 1, exp_read(32'h105, 2), c0 + 5);
    step();
    chk("clear_masks_req", 64'(mem_a), 64'h0);
    clear = 1'b0;
    run_until_done(1);

    // Write completes through a clear.
    step();
    set_ch(1, 1, 4, 32'h400, 64'h99887766_DDCCBBAA);
    c0 = cyc;
    exp_wr(32'h400, 8'hAA); exp_wr(32'h401, 8'hBB);
    exp_wr(32'h402, 8'hCC); exp_wr(32'h403, 8'hDD);
    exp_done(1, 0, '0, c0 + 5);
    req[1] = 1'b1;
    step(); step(); clear = 1'b1;
    step(); clear = 1'b0;
    run_until_done(1);

    // len=0 write -> one byte; len=15 read -> clamped to 8.
    step();
    set_ch(0, 1, 0, 32'h500, 64'h12EE);
    c0 = cyc;
    exp_wr(32'h500, 8'hEE);
    exp_done(0, 0, '0, c0 + 2);
    req[0] = 1'b1;
    run_until_done(0);
    step();
    set_ch(0, 0, 15, 32'h210, '0);
    c0 = cyc;
    exp_done(0, 1, exp_read(32'h210, 8), c0 + 10);
    req[0] = 1'b1;
    run_until_done(0);

    // rdy low for a cycle mid-write: no extra write, +1 latency.
    step();
    set_ch(0, 1, 2, 32'h600, 64'h5566);
    c0 = cyc;
    exp_wr(32'h600, 8'h66); exp_wr(32'h601, 8'h55);
    exp_done(0, 0, '0, c0 + 4);
    req[0] = 1'b1;
    step(); rdy = 1'b0;
    step(); rdy = 1'b1;
    run_until_done(0);

    // rdy low for 2 cycles mid-read: +2 latency, data intact.
    step();
    set_ch(1, 0, 4, 32'h100, '0);
    c0 = cyc;
    exp_done(1, 1, 64'h44332211, c0 + 8);
    req[1] = 1'b1;
    step();
    step(); rdy = 1'b0;
    step();
    step(); rdy = 1'b1;
    run_until_done(1);

    // Reset mid-read: outputs return to 0 at once, transaction dropped.
    step();
    set_ch(0, 0, 8, 32'h210, '0);
    req[0] = 1'b1;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    chk("rst_mem_a", 64'(mem_a), 64'h0);
    chk("rst_mem_wr", 64'(mem_wr), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_rdata", rdata, 64'h0);
    req = '0;
    step(); step();
    rst = 1'b0;
    repeat (15) step();

    chk("done_queue_empty", 64'(dq.size()), 64'h0);
    chk("write_queue_empty", 64'(wq.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
